// File: rtl/register_file_param.sv
// Small register file: one write port, a combinational and a registered read port,
// a flat snapshot bus, and a sequenced sweep that restores the power-on contents.
module register_file_param #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [AW-1:0]          raddr0,
  output logic [WIDTH-1:0]       rdata0,
  input  logic [AW-1:0]          raddr1,
  output logic [WIDTH-1:0]       rdata1,
  input  logic                   init_req,
  output logic                   busy,
  output logic                   init_done,
  output logic                   err,
  output logic [DEPTH*WIDTH-1:0] d_all
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Power-on value of an entry: its index modulo 2**WIDTH.
  function automatic logic [WIDTH-1:0] init_val(input logic [AW-1:0] idx);
    logic [31:0] wide;
    wide = 32'(idx);
    return wide[WIDTH-1:0];
  endfunction

  state_t           state_r, state_s;
  logic [AW-1:0]    cnt_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata1_r, rdata1_s;
  logic             busy_r, init_done_r, err_r;
  logic             waddr_ok_s, raddr0_ok_s, raddr1_ok_s;
  logic             wr_en_s, err_s;

  // Address range decode and write qualification.
  always_comb begin
    waddr_ok_s  = ({1'b0, waddr}  < DEPTH_W);
    raddr0_ok_s = ({1'b0, raddr0} < DEPTH_W);
    raddr1_ok_s = ({1'b0, raddr1} < DEPTH_W);
    wr_en_s     = we && waddr_ok_s && (state_r != INIT);
    // A write is flagged if it is dropped by the sweep or targets a missing entry.
    err_s       = we && ((state_r == INIT) || !waddr_ok_s);
  end

  // Sweep sequencing: next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (init_req) state_s = INIT;
        else          state_s = IDLE;
      end
      INIT: begin
        if (cnt_r == LAST_ADDR) state_s = DONE;
        else                    state_s = INIT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered read port 1 source, with write-first bypass outside the sweep.
  always_comb begin
    if (wr_en_s && (state_r == IDLE) && (waddr == raddr1)) begin
      rdata1_s = wdata;
    end else if (raddr1_ok_s) begin
      rdata1_s = mem_r[raddr1];
    end else begin
      rdata1_s = '0;
    end
  end

  // Control state, sweep counter and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      init_done_r <= 1'b0;
      err_r       <= 1'b0;
      rdata1_r    <= '0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= (state_r == INIT) ? cnt_r + AW'(1) : '0;
      busy_r      <= (state_s == INIT);
      init_done_r <= (state_s == DONE);
      err_r       <= err_s;
      rdata1_r    <= rdata1_s;
    end
  end

  // Storage: reset/sweep restore the power-on pattern, otherwise accept writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= init_val(AW'(i));
      end
    end else if (state_r == INIT) begin
      mem_r[cnt_r] <= init_val(cnt_r);
    end else if (wr_en_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read port and flat snapshot of every entry.
  always_comb begin
    if (raddr0_ok_s) rdata0 = mem_r[raddr0];
    else             rdata0 = '0;
    d_all = '0;
    for (int i = 0; i < DEPTH; i++) begin
      d_all[i*WIDTH +: WIDTH] = mem_r[i];
    end
  end

  assign rdata1    = rdata1_r;
  assign busy      = busy_r;
  assign init_done = init_done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench for register_file_param: stimulus queues hand-computed
// expectations tagged with a cycle; a negedge monitor pops and compares them.
module tb_register_file_param;

  localparam int WIDTH = 2;
  localparam int DEPTH = 3;
  localparam int AW    = 2;

  localparam int S_RD0  = 0;
  localparam int S_RD1  = 1;
  localparam int S_BUSY = 2;
  localparam int S_DONE = 3;
  localparam int S_ERR  = 4;
  localparam int S_DALL = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic [AW-1:0]          raddr0;
  logic [WIDTH-1:0]       rdata0;
  logic [AW-1:0]          raddr1;
  logic [WIDTH-1:0]       rdata1;
  logic                   init_req;
  logic                   busy;
  logic                   init_done;
  logic                   err;
  logic [DEPTH*WIDTH-1:0] d_all;

  typedef struct {
    string      name;
    int         at;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  register_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
    .init_req(init_req), .busy(busy), .init_done(init_done), .err(err),
    .d_all(d_all)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] actual(input int sig);
    case (sig)
      S_RD0:   return {6'd0, rdata0};
      S_RD1:   return {6'd0, rdata1};
      S_BUSY:  return {7'd0, busy};
      S_DONE:  return {7'd0, init_done};
      S_ERR:   return {7'd0, err};
      S_DALL:  return {2'd0, d_all};
      default: return 8'hFF;
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.at != cyc) begin
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d seen at %0d", e.name, e.at, cyc);
      end else if (actual(e.sig) !== e.exp) begin
        errors++;
        $display("FAIL %s: cycle %0d got %0h expected %0h", e.name, cyc, actual(e.sig), e.exp);
      end
    end
  end

  task automatic push_exp(input int sig, input logic [7:0] v, input string name);
    exp_t x;
    x.name = name;
    x.at   = cyc;
    x.sig  = sig;
    x.exp  = v;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr0 = '0; raddr1 = '0; init_req = 1'b0;

    step();  // cycle 1: release reset, check power-on contents
    reset  = 1'b1;
    raddr0 = 2'd2;
    push_exp(S_DALL, 8'b00_100100, "reset_d_all");
    push_exp(S_RD1,  8'd0, "reset_rdata1");
    push_exp(S_BUSY, 8'd0, "reset_busy");
    push_exp(S_DONE, 8'd0, "reset_init_done");
    push_exp(S_ERR,  8'd0, "reset_err");
    push_exp(S_RD0,  8'd2, "reset_rdata0_e2");

    step();  // cycle 2: write 3 to entry 1, port 0 still shows old value
    we = 1'b1; waddr = 2'd1; wdata = 2'd3; raddr0 = 2'd1; raddr1 = 2'd1;
    push_exp(S_RD0, 8'd1, "wr_old_rdata0");

    step();  // cycle 3: write visible; queue an out-of-range write
    we = 1'b1; waddr = 2'd3; wdata = 2'd1;
    push_exp(S_RD0,  8'd3, "wr_new_rdata0");
    push_exp(S_RD1,  8'd3, "wr_bypass_rdata1");
    push_exp(S_DALL, 8'b00_101100, "wr_d_all");
    push_exp(S_ERR,  8'd0, "wr_no_err");

    step();  // cycle 4: err pulse, nothing changed
    we = 1'b0; raddr0 = 2'd3;
    push_exp(S_ERR,  8'd1, "oor_err");
    push_exp(S_DALL, 8'b00_101100, "oor_d_all");
    push_exp(S_RD0,  8'd0, "oor_rdata0");
    push_exp(S_RD1,  8'd3, "oor_rdata1");

    step();  // cycle 5: err drops; start filling with 3
    push_exp(S_ERR, 8'd0, "oor_err_pulse_end");
    we = 1'b1; waddr = 2'd0; wdata = 2'd3; raddr1 = 2'd3;

    step();  // cycle 6
    push_exp(S_RD1, 8'd0, "oor_rdata1");
    push_exp(S_ERR, 8'd0, "fill_no_err");
    waddr = 2'd2;

    step();  // cycle 7: all 3s; request sweep with a simultaneous write
    raddr0 = 2'd0;
    push_exp(S_DALL, 8'b00_111111, "fill_d_all");
    push_exp(S_BUSY, 8'd0, "fill_busy");
    push_exp(S_RD0,  8'd3, "fill_rdata0");
    init_req = 1'b1; we = 1'b1; waddr = 2'd0; wdata = 2'd1; raddr1 = 2'd0;

    step();  // cycle 8: write committed, sweep started
    init_req = 1'b0; we = 1'b0;
    push_exp(S_BUSY, 8'd1, "sweep_busy_1");
    push_exp(S_DALL, 8'b00_111101, "sweep_wr_commit");
    push_exp(S_RD1,  8'd1, "sweep_rdata1_bypass");
    push_exp(S_RD0,  8'd1, "sweep_rdata0");
    push_exp(S_DONE, 8'd0, "sweep_no_done_1");

    step();  // cycle 9: entry 0 restored; try a write that must be dropped
    we = 1'b1; waddr = 2'd2; wdata = 2'd1;
    push_exp(S_BUSY, 8'd1, "sweep_busy_2");
    push_exp(S_DALL, 8'b00_111100, "sweep_d_all_1");
    push_exp(S_RD0,  8'd0, "sweep_rdata0_live");
    push_exp(S_RD1,  8'd1, "sweep_rdata1_old");

    step();  // cycle 10
    we = 1'b0;
    push_exp(S_BUSY, 8'd1, "sweep_busy_3");
    push_exp(S_ERR,  8'd1, "sweep_drop_err");
    push_exp(S_DALL, 8'b00_110100, "sweep_d_all_2");
    push_exp(S_RD1,  8'd0, "sweep_rdata1_live");

    step();  // cycle 11: sweep complete
    push_exp(S_BUSY, 8'd0, "done_busy");
    push_exp(S_DONE, 8'd1, "done_pulse");
    push_exp(S_ERR,  8'd0, "done_err_clear");
    push_exp(S_DALL, 8'b00_100100, "done_d_all");

    step();  // cycle 12: pulse ends; start a second sweep after a write
    push_exp(S_DONE, 8'd0, "done_pulse_end");
    push_exp(S_BUSY, 8'd0, "idle_busy");
    init_req = 1'b1; we = 1'b1; waddr = 2'd2; wdata = 2'd0;

    step();  // cycle 13
    init_req = 1'b0; we = 1'b0;
    push_exp(S_BUSY, 8'd1, "sweep2_busy");
    push_exp(S_DALL, 8'b00_000100, "sweep2_d_all");

    step();  // cycle 14: reset in the middle of the sweep
    reset = 1'b0;
    #1;
    push_exp(S_BUSY, 8'd0, "abort_busy");
    push_exp(S_DALL, 8'b00_100100, "abort_d_all");
    push_exp(S_RD1,  8'd0, "abort_rdata1");
    push_exp(S_DONE, 8'd0, "abort_no_done");

    step();  // cycle 15
    reset = 1'b1;
    push_exp(S_BUSY, 8'd0, "post_abort_busy");
    push_exp(S_DONE, 8'd0, "post_abort_done_1");
    push_exp(S_DALL, 8'b00_100100, "post_abort_d_all");

    step();  // cycle 16
    push_exp(S_DONE, 8'd0, "post_abort_done_2");
    push_exp(S_BUSY, 8'd0, "post_abort_busy_2");

    step();
    step();
    if (q.size() != 0) begin
      $display("FAIL leftover: %0d expectations never checked, expected 0", q.size());
      checks += q.size();
      errors += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
